// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//   Serialises a setpoint code into one 16-bit write frame for an
//   MCP4921-class 12-bit SPI DAC, then strobes LDAC_n so the new code reaches
//   the analog output.
//
//   Frame: [15]=0 (channel A), [14]=BUF, [13]=GA_N, [12]=shdn_n,
//          [11:0]=data_in left-justified (unused LSBs zero).
//
//   Ports
//     clk, rst        system clock, synchronous active-high reset
//     data_in[BITS]   DAC code (unsigned), captured on acceptance
//     shdn_n          frame bit 12, captured on acceptance
//     valid / ready   request handshake; ready is high only in IDLE
//     done            one-cycle pulse after LDAC_n has latched the frame
//     cs_n, sclk,     SPI mode 0 (sclk idles low), MSB first
//     mosi
//     ldac_n          DAC latch strobe, active low
// -----------------------------------------------------------------------------
module dac_spi_tx #(
    parameter int   BITS    = 12,
    parameter int   CLK_DIV = 2,
    parameter logic BUF     = 1'b0,
    parameter logic GA_N    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] data_in,
    input  logic            shdn_n,
    input  logic            valid,
    output logic            ready,
    output logic            done,
    output logic            cs_n,
    output logic            sclk,
    output logic            mosi,
    output logic            ldac_n
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, CS_HOLD, LDAC} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;   // clk cycles within the current half-period
    logic [3:0]    fall_cnt;  // sclk falling edges seen in this frame
    logic [14:0]   shreg;     // frame bits still to go out; bit 15 goes straight to mosi

    logic        div_end;
    logic [11:0] code;
    logic [15:0] frame;

    assign div_end = (div_cnt == DW'(CLK_DIV - 1));
    assign code    = 12'(data_in) << (12 - BITS);
    assign frame   = {1'b0, BUF, GA_N, shdn_n, code};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            cs_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ldac_n   <= 1'b1;
            div_cnt  <= '0;
            fall_cnt <= '0;
            shreg    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // ready is high throughout IDLE, so valid alone accepts.
                    if (valid) begin
                        shreg    <= frame[14:0];
                        mosi     <= frame[15];
                        cs_n     <= 1'b0;
                        sclk     <= 1'b0;
                        ready    <= 1'b0;
                        div_cnt  <= '0;
                        fall_cnt <= '0;
                        state    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= ~sclk;
                        if (sclk) begin
                            // Falling edge: present the next bit for the
                            // following rising edge; after the 16th, park low.
                            fall_cnt <= fall_cnt + 4'd1;
                            if (fall_cnt == 4'd15) begin
                                mosi  <= 1'b0;
                                state <= CS_HOLD;
                            end else begin
                                mosi  <= shreg[14];
                                shreg <= {shreg[13:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                CS_HOLD: begin
                    // Keep cs_n low one half-period after the last falling edge.
                    if (div_end) begin
                        div_cnt <= '0;
                        cs_n    <= 1'b1;
                        state   <= LDAC;
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                LDAC: begin
                    // Two half-periods: first with ldac_n high (cs_n setup),
                    // second with ldac_n low (latch pulse).
                    if (div_end) begin
                        div_cnt <= '0;
                        if (ldac_n) begin
                            ldac_n <= 1'b0;
                        end else begin
                            ldac_n <= 1'b1;
                            done   <= 1'b1;
                            ready  <= 1'b1;
                            state  <= IDLE;
                        end
                    end else begin
                        div_cnt <= div_cnt + DW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// -----------------------------------------------------------------------------
// tb_dac_spi_tx
//   Two instances: A (BITS=12, CLK_DIV=2) and B (BITS=10, CLK_DIV=1).
//   A DAC model per instance shifts in mosi on sclk rising edges while cs_n is
//   low and latches the word on the ldac_n falling edge; on each done pulse the
//   latched word is compared with the next entry of that instance's queue.
//   Directed steps also check every output cycle-by-cycle against the frame
//   timing expressed relative to the acceptance cycle.
// -----------------------------------------------------------------------------
module tb_dac_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [11:0] data_a  = '0;
    logic        shdn_a  = 1'b0;
    logic        valid_a = 1'b0;
    logic        ready_a, done_a, cs_n_a, sclk_a, mosi_a, ldac_n_a;

    logic [9:0]  data_b  = '0;
    logic        shdn_b  = 1'b0;
    logic        valid_b = 1'b0;
    logic        ready_b, done_b, cs_n_b, sclk_b, mosi_b, ldac_n_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dac_spi_tx #(.BITS(12), .CLK_DIV(2), .BUF(1'b0), .GA_N(1'b1)) u_a (
        .clk(clk), .rst(rst), .data_in(data_a), .shdn_n(shdn_a), .valid(valid_a),
        .ready(ready_a), .done(done_a), .cs_n(cs_n_a), .sclk(sclk_a),
        .mosi(mosi_a), .ldac_n(ldac_n_a)
    );

    dac_spi_tx #(.BITS(10), .CLK_DIV(1), .BUF(1'b0), .GA_N(1'b1)) u_b (
        .clk(clk), .rst(rst), .data_in(data_b), .shdn_n(shdn_b), .valid(valid_b),
        .ready(ready_b), .done(done_b), .cs_n(cs_n_b), .sclk(sclk_b),
        .mosi(mosi_b), .ldac_n(ldac_n_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- DAC models + scoreboards ----------------
    logic [15:0] qa[$];
    logic [15:0] qb[$];

    logic [15:0] a_sh = '0, a_lat = '0;
    logic        a_sclk_q = 1'b0, a_cs_q = 1'b1, a_ldac_q = 1'b1;
    int          a_bits = 0, a_done_cnt = 0, a_ldac_cnt = 0, a_cs_hi = 0, a_cs_hi_last = 0;

    always @(posedge clk) begin
        #1;
        if (cs_n_a) a_cs_hi++;
        if (!cs_n_a && a_cs_q) begin
            a_cs_hi_last = a_cs_hi;
            a_cs_hi      = 0;
            a_bits       = 0;
        end
        if (!cs_n_a && sclk_a && !a_sclk_q) begin
            a_sh = {a_sh[14:0], mosi_a};
            a_bits++;
        end
        if (!ldac_n_a && a_ldac_q) begin
            a_ldac_cnt++;
            a_lat = (a_bits == 16) ? a_sh : 16'hxxxx;
        end
        if (done_a) begin
            a_done_cnt++;
            if (qa.size() == 0) check("a_unexpected_done", 32'd1, 32'd0);
            else                check("a_frame", {16'd0, a_lat}, {16'd0, qa.pop_front()});
        end
        a_sclk_q = sclk_a;
        a_cs_q   = cs_n_a;
        a_ldac_q = ldac_n_a;
    end

    logic [15:0] b_sh = '0, b_lat = '0;
    logic        b_sclk_q = 1'b0, b_cs_q = 1'b1, b_ldac_q = 1'b1;
    int          b_bits = 0, b_done_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (!cs_n_b && b_cs_q) b_bits = 0;
        if (!cs_n_b && sclk_b && !b_sclk_q) begin
            b_sh = {b_sh[14:0], mosi_b};
            b_bits++;
        end
        if (!ldac_n_b && b_ldac_q) b_lat = (b_bits == 16) ? b_sh : 16'hxxxx;
        if (done_b) begin
            b_done_cnt++;
            if (qb.size() == 0) check("b_unexpected_done", 32'd1, 32'd0);
            else                check("b_frame", {16'd0, b_lat}, {16'd0, qb.pop_front()});
        end
        b_sclk_q = sclk_b;
        b_cs_q   = cs_n_b;
        b_ldac_q = ldac_n_b;
    end

    // {ready, done, cs_n, sclk, mosi, ldac_n}
    function automatic logic [5:0] outs(input bit sel_b);
        return sel_b ? {ready_b, done_b, cs_n_b, sclk_b, mosi_b, ldac_n_b}
                     : {ready_a, done_a, cs_n_a, sclk_a, mosi_a, ldac_n_a};
    endfunction

    task automatic check_idle(input string tag, input bit sel_b);
        logic [5:0] o;
        o = outs(sel_b);
        check({tag, "_ready"},  32'(o[5]), 32'd1);
        check({tag, "_done"},   32'(o[4]), 32'd0);
        check({tag, "_cs_n"},   32'(o[3]), 32'd1);
        check({tag, "_sclk"},   32'(o[2]), 32'd0);
        check({tag, "_mosi"},   32'(o[1]), 32'd0);
        check({tag, "_ldac_n"}, 32'(o[0]), 32'd1);
    endtask

    // Called in cycle T0+1 (just after the acceptance edge); returns in the
    // done cycle T0+1+35d. Optional valid pulses on instance A at p1/p2.
    task automatic run_frame(input string tag, input int d, input logic [15:0] f,
                             input bit sel_b, input int p1, input int p2);
        logic [5:0] o;
        int m;
        logic e_cs, e_sclk, e_mosi, e_ldac, e_done;
        for (int n = 1; n <= 1 + 35 * d; n++) begin
            if (n > 1) tick();
            m      = n - 1;
            e_cs   = (n <= 33 * d) ? 1'b0 : 1'b1;
            e_sclk = (m < 32 * d) ? (((m / d) % 2) == 1) : 1'b0;
            e_mosi = (m < 32 * d) ? f[15 - m / (2 * d)] : 1'b0;
            e_ldac = (n >= 1 + 34 * d && n <= 35 * d) ? 1'b0 : 1'b1;
            e_done = (n == 1 + 35 * d);
            o = outs(sel_b);
            check($sformatf("%s_ready_n%0d",  tag, n), 32'(o[5]), 32'(e_done));
            check($sformatf("%s_done_n%0d",   tag, n), 32'(o[4]), 32'(e_done));
            check($sformatf("%s_cs_n_n%0d",   tag, n), 32'(o[3]), 32'(e_cs));
            check($sformatf("%s_sclk_n%0d",   tag, n), 32'(o[2]), 32'(e_sclk));
            check($sformatf("%s_mosi_n%0d",   tag, n), 32'(o[1]), 32'(e_mosi));
            check($sformatf("%s_ldac_n_n%0d", tag, n), 32'(o[0]), 32'(e_ldac));
            if (p1 > 0) valid_a = (n == p1) || (n == p2);
        end
    endtask

    initial begin
        // ---- reset ----
        tick(); tick(); tick();
        check_idle("rst_a", 1'b0);
        check_idle("rst_b", 1'b1);
        rst = 1'b0;
        tick();
        check_idle("idle_a", 1'b0);

        // ---- single frame, D=2, BITS=12 ----
        data_a = 12'hA5C; shdn_a = 1'b1; valid_a = 1'b1;
        qa.push_back(16'h3A5C);
        tick();
        valid_a = 1'b0;
        data_a  = 12'h000;      // post-acceptance change must not matter
        run_frame("f1", 2, 16'h3A5C, 1'b0, 0, 0);
        tick();
        check("f1_done_cleared", 32'(done_a), 32'd0);
        check("f1_done_cnt", 32'(a_done_cnt), 32'd1);
        check("f1_ldac_cnt", 32'(a_ldac_cnt), 32'd1);

        // ---- BITS=10, D=1, shutdown ----
        data_b = 10'h3FF; shdn_b = 1'b0; valid_b = 1'b1;
        qb.push_back(16'h2FFC);
        tick();
        valid_b = 1'b0;
        run_frame("fb", 1, 16'h2FFC, 1'b1, 0, 0);
        tick();
        check("fb_done_cnt", 32'(b_done_cnt), 32'd1);

        // ---- back-to-back with valid held high ----
        data_a = 12'h000; shdn_a = 1'b1; valid_a = 1'b1;
        qa.push_back(16'h3000);
        qa.push_back(16'h3FFF);
        tick();
        data_a = 12'hFFF;
        run_frame("bb1", 2, 16'h3000, 1'b0, 0, 0);   // valid stays high throughout
        tick();                                       // done cycle was the new T0
        valid_a = 1'b0;
        run_frame("bb2", 2, 16'h3FFF, 1'b0, 0, 0);
        tick();
        // cs_n rises at T0+1+33D and falls again at T0+2+35D: 2D+1 high cycles.
        check("bb_cs_high", 32'(a_cs_hi_last), 32'd5);
        check("bb_done_cnt", 32'(a_done_cnt), 32'd3);

        // ---- reset mid-SHIFT, together with a valid ----
        data_a = 12'h123; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int n = 2; n <= 20; n++) tick();
        check("ab_cs_low_n20", 32'(cs_n_a), 32'd0);
        rst = 1'b1; valid_a = 1'b1;
        tick();
        check_idle("ab_n21", 1'b0);
        rst = 1'b0; valid_a = 1'b0;
        tick();
        check("ab_not_accepted_cs", 32'(cs_n_a), 32'd1);
        check("ab_not_accepted_rdy", 32'(ready_a), 32'd1);
        for (int n = 0; n < 80; n++) tick();
        check("ab_no_done", 32'(a_done_cnt), 32'd3);
        check("ab_no_ldac", 32'(a_ldac_cnt), 32'd3);
        check_idle("ab_after", 1'b0);

        // ---- reset during LDAC ----
        data_a = 12'h456; valid_a = 1'b1;
        tick();
        valid_a = 1'b0;
        for (int n = 2; n <= 69; n++) tick();
        check("al_ldac_low", 32'(ldac_n_a), 32'd0);
        rst = 1'b1;
        tick();
        check("al_ldac_high", 32'(ldac_n_a), 32'd1);
        check("al_done", 32'(done_a), 32'd0);
        rst = 1'b0;
        tick(); tick(); tick();
        check("al_no_done", 32'(a_done_cnt), 32'd3);
        data_a = 12'h7E1; shdn_a = 1'b1; valid_a = 1'b1;
        qa.push_back(16'h37E1);
        tick();
        valid_a = 1'b0;
        run_frame("al_fresh", 2, 16'h37E1, 1'b0, 0, 0);
        tick();

        // ---- valid pulses during a frame are ignored ----
        data_a = 12'h0F0; shdn_a = 1'b1; valid_a = 1'b1;
        qa.push_back(16'h30F0);
        tick();
        valid_a = 1'b0;
        data_a  = 12'hFFF;
        run_frame("ign", 2, 16'h30F0, 1'b0, 5, 40);
        valid_a = 1'b0;
        for (int n = 0; n < 10; n++) tick();
        check_idle("ign_after", 1'b0);
        check("ign_done_cnt", 32'(a_done_cnt), 32'd5);
        check("qa_empty", 32'(qa.size()), 32'd0);
        check("qb_empty", 32'(qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
